// File: rtl/cache_mem_arbiter.sv
// Arbitrates cache refill (line read) and writeback (line write) bursts onto a
// single word-wide memory port, one beat per mem_ack_i, critical word first.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no burst; arbitrate pending refill/writeback requests
// RD_BURST | refill burst, words forwarded to the cache as they arrive
// WR_BURST | writeback burst, words pulled from the victim buffer
// DONE     | one-cycle completion ack to the requester just served
module cache_mem_arbiter #(
  parameter int ADR_WIDTH  = 32,
  parameter int DATA_WIDTH = 32,
  parameter int WORD_NUM   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rf_req_i,
  input  logic [ADR_WIDTH-1:0]  rf_adr_i,
  output logic                  rf_valid_o,
  output logic [DATA_WIDTH-1:0] rf_dat_o,
  output logic [1:0]            rf_word_o,
  output logic                  rf_ack_o,
  input  logic                  wb_req_i,
  input  logic [ADR_WIDTH-1:0]  wb_adr_i,
  output logic [1:0]            wb_word_o,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  output logic                  wb_ack_o,
  output logic                  mem_req_o,
  output logic [ADR_WIDTH-1:0]  mem_adr_o,
  output logic                  mem_rdwr_o,
  output logic [DATA_WIDTH-1:0] mem_dat_o,
  input  logic [DATA_WIDTH-1:0] mem_dat_i,
  input  logic                  mem_ack_i
);

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;

  localparam logic       GRANT_RF  = 1'b0;
  localparam logic       GRANT_WB  = 1'b1;
  localparam logic [1:0] LAST_BEAT = 2'(WORD_NUM - 1);

  state_t               state_q, state_d;
  logic [ADR_WIDTH-3:0] line_q, line_d;
  logic [1:0]           word_q, word_d;
  logic [1:0]           beat_q, beat_d;
  logic                 last_grant_q, last_grant_d;

  logic same_line;
  logic grant_wb;

  assign same_line = (rf_adr_i[ADR_WIDTH-1:2] == wb_adr_i[ADR_WIDTH-1:2]);

  // A writeback to the line being refilled must land first, otherwise the
  // refill would return stale data; otherwise alternate on conflict.
  always_comb begin
    grant_wb = 1'b0;
    if (wb_req_i && !rf_req_i)
      grant_wb = 1'b1;
    else if (wb_req_i && rf_req_i)
      grant_wb = same_line || (last_grant_q == GRANT_RF);
  end

  always_comb begin
    state_d      = state_q;
    line_d       = line_q;
    word_d       = word_q;
    beat_d       = beat_q;
    last_grant_d = last_grant_q;
    rf_valid_o   = 1'b0;
    rf_dat_o     = '0;
    rf_word_o    = 2'd0;
    rf_ack_o     = 1'b0;
    wb_word_o    = 2'd0;
    wb_ack_o     = 1'b0;
    mem_req_o    = 1'b0;
    mem_rdwr_o   = 1'b0;
    mem_dat_o    = '0;
    mem_adr_o    = {line_q, word_q};

    case (state_q)
      IDLE: begin
        if (grant_wb) begin
          state_d = WR_BURST;
          line_d  = wb_adr_i[ADR_WIDTH-1:2];
          word_d  = 2'd0;
          beat_d  = 2'd0;
        end else if (rf_req_i) begin
          state_d = RD_BURST;
          line_d  = rf_adr_i[ADR_WIDTH-1:2];
          word_d  = rf_adr_i[1:0];
          beat_d  = 2'd0;
        end
      end

      RD_BURST: begin
        mem_req_o  = 1'b1;
        rf_valid_o = mem_ack_i;
        rf_dat_o   = mem_dat_i;
        rf_word_o  = word_q;
        if (mem_ack_i) begin
          word_d = word_q + 2'd1;
          beat_d = beat_q + 2'd1;
          if (beat_q == LAST_BEAT) begin
            state_d      = DONE;
            last_grant_d = GRANT_RF;
          end
        end
      end

      WR_BURST: begin
        mem_req_o  = 1'b1;
        mem_rdwr_o = 1'b1;
        wb_word_o  = word_q;
        mem_dat_o  = wb_dat_i;
        if (mem_ack_i) begin
          word_d = word_q + 2'd1;
          beat_d = beat_q + 2'd1;
          if (beat_q == LAST_BEAT) begin
            state_d      = DONE;
            last_grant_d = GRANT_WB;
          end
        end
      end

      DONE: begin
        // last_grant was updated on the final beat, so it names this burst
        rf_ack_o = (last_grant_q == GRANT_RF);
        wb_ack_o = (last_grant_q == GRANT_WB);
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      line_q       <= '0;
      word_q       <= 2'd0;
      beat_q       <= 2'd0;
      last_grant_q <= GRANT_RF;
    end else begin
      state_q      <= state_d;
      line_q       <= line_d;
      word_q       <= word_d;
      beat_q       <= beat_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: a memory model acking every other
// cycle, requesters that drop their request after the ack, recorded beats.
module tb_cache_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        rf_req_i;
  logic [31:0] rf_adr_i;
  logic        rf_valid_o;
  logic [31:0] rf_dat_o;
  logic [1:0]  rf_word_o;
  logic        rf_ack_o;
  logic        wb_req_i;
  logic [31:0] wb_adr_i;
  logic [1:0]  wb_word_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_o;
  logic        mem_req_o;
  logic [31:0] mem_adr_o;
  logic        mem_rdwr_o;
  logic [31:0] mem_dat_o;
  logic [31:0] mem_dat_i;
  logic        mem_ack_i;

  cache_mem_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .rf_req_i   (rf_req_i),
    .rf_adr_i   (rf_adr_i),
    .rf_valid_o (rf_valid_o),
    .rf_dat_o   (rf_dat_o),
    .rf_word_o  (rf_word_o),
    .rf_ack_o   (rf_ack_o),
    .wb_req_i   (wb_req_i),
    .wb_adr_i   (wb_adr_i),
    .wb_word_o  (wb_word_o),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_o   (wb_ack_o),
    .mem_req_o  (mem_req_o),
    .mem_adr_o  (mem_adr_o),
    .mem_rdwr_o (mem_rdwr_o),
    .mem_dat_o  (mem_dat_o),
    .mem_dat_i  (mem_dat_i),
    .mem_ack_i  (mem_ack_i)
  );

  // victim buffer: word data is a pure function of the requested index
  assign wb_dat_i = 32'hB0B0_0000 | {30'd0, wb_word_o};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_beat_cyc = 0;
  int rf_ack_cyc = 0;
  int idle_activity = 0;
  logic spurious = 1'b0;

  logic [31:0] beat_adr[$];
  logic [31:0] beat_rw[$];
  logic [31:0] beat_wdat[$];
  logic [31:0] wb_words[$];
  logic [31:0] rf_words[$];
  logic [31:0] rf_dats[$];
  int          ack_order[$];   // 0 = refill ack, 1 = writeback ack

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    beat_adr.delete();
    beat_rw.delete();
    beat_wdat.delete();
    wb_words.delete();
    rf_words.delete();
    rf_dats.delete();
    ack_order.delete();
  endtask

  // One clock: memory responds at negedge, outputs are sampled 1 time unit later.
  task automatic cycle();
    @(negedge clk);
    if (spurious)
      mem_ack_i = 1'b1;
    else
      mem_ack_i = mem_req_o && !mem_ack_i;
    mem_dat_i = 32'hD000_0000 ^ mem_adr_o;
    #1;
    cyc++;
    if (mem_req_o && mem_ack_i) begin
      beat_adr.push_back(mem_adr_o);
      beat_rw.push_back({31'd0, mem_rdwr_o});
      beat_wdat.push_back(mem_dat_o);
      wb_words.push_back({30'd0, wb_word_o});
      last_beat_cyc = cyc;
    end
    if (rf_valid_o) begin
      rf_words.push_back({30'd0, rf_word_o});
      rf_dats.push_back(rf_dat_o);
    end
    if (rf_ack_o) begin
      ack_order.push_back(0);
      rf_ack_cyc = cyc;
      rf_req_i = 1'b0;
    end
    if (wb_ack_o) begin
      ack_order.push_back(1);
      wb_req_i = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rf_req_i = 1'b0;
    wb_req_i = 1'b0;
    repeat (2) cycle();
    rst = 1'b0;
    cycle();
  endtask

  task automatic run_until(input int n_acks, input int budget);
    for (int i = 0; i < budget && ack_order.size() < n_acks; i++) cycle();
    chk("ack_count", ack_order.size(), n_acks);
    cycle();
  endtask

  initial begin
    rst = 1'b1;
    rf_req_i = 1'b0;
    rf_adr_i = '0;
    wb_req_i = 1'b0;
    wb_adr_i = '0;
    mem_ack_i = 1'b0;
    mem_dat_i = '0;
    do_reset();

    // reset state
    chk("rst_mem_req", {31'd0, mem_req_o}, 0);
    chk("rst_mem_adr", mem_adr_o, 0);
    chk("rst_mem_rdwr", {31'd0, mem_rdwr_o}, 0);
    chk("rst_mem_dat", mem_dat_o, 0);
    chk("rst_rf_valid", {31'd0, rf_valid_o}, 0);
    chk("rst_rf_dat", rf_dat_o, 0);
    chk("rst_rf_word", {30'd0, rf_word_o}, 0);
    chk("rst_acks", {30'd0, rf_ack_o, wb_ack_o}, 0);
    chk("rst_wb_word", {30'd0, wb_word_o}, 0);

    // spurious acks in IDLE
    spurious = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (mem_req_o || rf_valid_o) idle_activity++;
    end
    spurious = 1'b0;
    cycle();
    chk("idle_spurious", idle_activity, 0);

    // refill only, critical word 2
    clear_log();
    rf_adr_i = 32'h0000_0106;
    rf_req_i = 1'b1;
    run_until(1, 40);
    begin
      logic [31:0] exp_adr [4] = '{32'h106, 32'h107, 32'h104, 32'h105};
      logic [31:0] exp_wrd [4] = '{2, 3, 0, 1};
      for (int i = 0; i < 4; i++) begin
        chk("rf_adr", beat_adr[i], exp_adr[i]);
        chk("rf_rdwr", beat_rw[i], 0);
        chk("rf_word", rf_words[i], exp_wrd[i]);
        chk("rf_dat", rf_dats[i], 32'hD000_0000 ^ exp_adr[i]);
      end
    end
    chk("rf_beats", rf_words.size(), 4);
    chk("rf_ack_lat", rf_ack_cyc - last_beat_cyc, 1);
    chk("rf_ack_kind", ack_order[0], 0);

    // writeback only
    clear_log();
    wb_adr_i = 32'h0000_0208;
    wb_req_i = 1'b1;
    run_until(1, 40);
    for (int i = 0; i < 4; i++) begin
      chk("wb_adr", beat_adr[i], 32'h208 + i);
      chk("wb_rdwr", beat_rw[i], 1);
      chk("wb_word", wb_words[i], i);
      chk("wb_dat", beat_wdat[i], 32'hB0B0_0000 + i);
    end
    chk("wb_ack_kind", ack_order[0], 1);
    chk("wb_no_rf_valid", rf_words.size(), 0);

    // same line while last_grant = writeback: writeback still first
    clear_log();
    rf_adr_i = 32'h0000_0302;
    wb_adr_i = 32'h0000_0300;
    rf_req_i = 1'b1;
    wb_req_i = 1'b1;
    run_until(2, 80);
    chk("same_first", ack_order[0], 1);
    chk("same_second", ack_order[1], 0);
    chk("same_adr0", beat_adr[0], 32'h300);
    chk("same_adr4", beat_adr[4], 32'h302);

    // different lines after reset: wb, rf; then wb again
    do_reset();
    clear_log();
    rf_adr_i = 32'h0000_0400;
    wb_adr_i = 32'h0000_0500;
    rf_req_i = 1'b1;
    wb_req_i = 1'b1;
    run_until(2, 80);
    rf_adr_i = 32'h0000_0600;
    wb_adr_i = 32'h0000_0700;
    rf_req_i = 1'b1;
    wb_req_i = 1'b1;
    run_until(4, 80);
    chk("pair_order0", ack_order[0], 1);
    chk("pair_order1", ack_order[1], 0);
    chk("pair_order2", ack_order[2], 1);
    chk("pair_order3", ack_order[3], 0);
    chk("pair_adr0", beat_adr[0], 32'h500);
    chk("pair_adr4", beat_adr[4], 32'h400);
    chk("pair_adr8", beat_adr[8], 32'h700);
    chk("pair_adr12", beat_adr[12], 32'h600);

    // reset mid-refill after the 2nd beat
    clear_log();
    rf_adr_i = 32'h0000_010D;
    rf_req_i = 1'b1;
    for (int i = 0; i < 40 && beat_adr.size() < 2; i++) cycle();
    chk("mid_beats", beat_adr.size(), 2);
    rst = 1'b1;
    rf_req_i = 1'b0;
    cycle();
    chk("mid_rst_mreq", {31'd0, mem_req_o}, 0);
    rst = 1'b0;
    repeat (3) cycle();
    chk("mid_no_ack", ack_order.size(), 0);
    chk("mid_no_req", {31'd0, mem_req_o}, 0);
    clear_log();
    rf_req_i = 1'b1;
    run_until(1, 40);
    begin
      logic [31:0] exp_adr [4] = '{32'h10D, 32'h10E, 32'h10F, 32'h10C};
      for (int i = 0; i < 4; i++) begin
        chk("restart_adr", beat_adr[i], exp_adr[i]);
        chk("restart_word", rf_words[i], (i + 1) % 4);
      end
    end

    // acks every cycle, including during DONE and the following IDLE
    clear_log();
    spurious = 1'b1;
    rf_adr_i = 32'h0000_020F;
    rf_req_i = 1'b1;
    run_until(1, 40);
    repeat (3) cycle();
    spurious = 1'b0;
    cycle();
    chk("spur_valid_cnt", rf_words.size(), 4);
    chk("spur_adr0", beat_adr[0], 32'h20F);
    chk("spur_adr3", beat_adr[3], 32'h20E);
    chk("spur_word3", rf_words[3], 2);
    chk("spur_one_ack", ack_order.size(), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 Parameter ADR_WIDTH, default 32: word address width; bits [1:0] select a word within a line, bits [ADR_WIDTH-1:2] select the line.
REQ-002 Parameter DATA_WIDTH, default 32: word width.
REQ-003 Parameter WORD_NUM, default 4: words per line and beats per burst.
REQ-004 Ports:
clk  in  1  single clock; all state changes on its rising edge.
rst  in  1  synchronous, active-high reset.
rf_req_i  in  1  refill (line read) request from the cache; held until rf_ack_o.
rf_adr_i  in  ADR_WIDTH  refill address; bits [1:0] give the critical word.
rf_valid_o  out  1  refill word valid this cycle.
rf_dat_o  out  DATA_WIDTH  refill word data.
rf_word_o  out  2  word index of the current refill beat.
rf_ack_o  out  1  one-cycle pulse: refill burst complete.
wb_req_i  in  1  writeback (line write) request from the victim buffer; held until wb_ack_o.
wb_adr_i  in  ADR_WIDTH  writeback line address; bits [1:0] ignored.
wb_word_o  out  2  word index the victim buffer must present on wb_dat_i.
wb_dat_i  in  DATA_WIDTH  writeback word, combinational from wb_word_o.
wb_ack_o  out  1  one-cycle pulse: writeback burst complete.
mem_req_o  out  1  memory beat request, held until mem_ack_i.
mem_adr_o  out  ADR_WIDTH  memory word address.
mem_rdwr_o  out  1  0 = read, 1 = write.
mem_dat_o  out  DATA_WIDTH  write data.
mem_dat_i  in  DATA_WIDTH  read data, valid with mem_ack_i.
mem_ack_i  in  1  one-cycle pulse per completed beat.

Function
REQ-005 The FSM SHALL have exactly four states: IDLE, RD_BURST, WR_BURST and DONE.
REQ-006 In IDLE with only rf_req_i high, the FSM SHALL go to RD_BURST; with only wb_req_i high, it SHALL go to WR_BURST.
REQ-007 In IDLE with both requests high:
- if rf_adr_i[ADR_WIDTH-1:2] equals wb_adr_i[ADR_WIDTH-1:2], WR_BURST SHALL win;
- otherwise the requester not granted last (last_grant register) SHALL win.
REQ-008 On entry to a burst, the arbiter SHALL latch the granted address, load the word counter and clear the beat counter.
- Refill: word counter loads rf_adr_i[1:0].
- Writeback: word counter loads 0.
REQ-009 In a burst, mem_req_o SHALL be 1 from the first cycle of the burst state until the fourth mem_ack_i.
- mem_adr_o = {latched line, word counter}.
- mem_rdwr_o = 0 in RD_BURST, 1 in WR_BURST.
REQ-010 Each mem_ack_i in a burst SHALL increment the word counter modulo 4 (3 wraps to 0) and the beat counter; mem_adr_o SHALL reflect the new word in the next cycle.
REQ-011 In RD_BURST: rf_valid_o = mem_ack_i, rf_dat_o = mem_dat_i, rf_word_o = word counter, all combinational (zero latency).
REQ-012 In WR_BURST: wb_word_o = word counter and mem_dat_o = wb_dat_i, combinational.
REQ-013 On the fourth mem_ack_i the FSM SHALL go to DONE and update last_grant.
REQ-014 DONE SHALL last one cycle and assert the matching ack (rf_ack_o or wb_ack_o), then return to IDLE. The requester SHALL drop its request at the edge that ends the ack cycle.
REQ-015 Outside the burst states: mem_req_o, rf_valid_o, rf_ack_o, wb_ack_o = 0; mem_dat_o = 0; mem_ack_i and mem_dat_i SHALL be ignored.
REQ-016 A request arriving while a burst is active SHALL wait in IDLE for arbitration; bursts SHALL never be interleaved or aborted by requests.

Reset
REQ-017 With rst high at a clock edge, the arbiter SHALL go to IDLE and clear both counters, last_grant (refill) and all latched addresses. This holds in any state, including mid-burst.
REQ-018 After reset, all outputs SHALL be 0 and mem_req_o SHALL be low from the first cycle after the reset edge.

Verification
REQ-019 Refill only: rf_adr_i=0x00000106, memory acks every 2nd cycle -> mem_adr_o 0x106, 0x107, 0x104, 0x105 with rdwr=0; rf_word_o 2, 3, 0, 1; rf_ack_o one cycle after the 4th ack.
REQ-020 Writeback only: wb_adr_i=0x00000208 -> mem_adr_o 0x208..0x20B with rdwr=1; mem_dat_o tracks wb_dat_i for wb_word_o 0..3; one wb_ack_o pulse.
REQ-021 Same-cycle requests to different lines, then the same pair again:
- first pair after reset -> writeback, then refill;
- second pair -> writeback (alternation from last_grant = refill).
REQ-022 Same-cycle requests to the same line (both 0x300 line) while last_grant = writeback -> writeback still granted first.
REQ-023 rst asserted after the 2nd beat of a refill -> IDLE next cycle, mem_req_o=0, no rf_ack_o; a new refill restarts at its critical word.
REQ-024 Spurious mem_ack_i in IDLE and DONE -> no counter change, no rf_valid_o.
